seq_scan: RTL and testbench

SEQ_SCAN -- requirements
Module: seq_scan

---
 rtl/seq_scan_pkg.sv | 19 +
 rtl/seq_win_match.sv | 24 ++
 rtl/seq_scan.sv | 138 +++++++++++++
 tb/tb_seq_scan.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: FSM state encoding, match-mode constants and a width helper
// shared by the seq_scan block and its window comparator.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_OVL  = 1'b0;
    localparam logic MODE_NOVL = 1'b1;

    // $clog2 that never yields a zero-width vector
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_win_match.sv
// seq_win_match: picks window `index` out of `word` (MSB first) and
// compares it against `pattern`. Ports: word, index, pattern in; hit out.
module seq_win_match
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 3,
    parameter int IDX_W  = 3
) (
    input  logic [DATA_W-1:0] word,
    input  logic [IDX_W-1:0]  index,
    input  logic [PAT_W-1:0]  pattern,
    output logic              hit
);

    localparam int TOP = DATA_W - 1;

    logic [PAT_W-1:0] window;

    // window i spans bits TOP-i down to TOP-i-PAT_W+1
    assign window = word[TOP - int'(index) -: PAT_W];
    assign hit    = (window == pattern);

endmodule

// File: rtl/seq_scan.sv
// seq_scan: serial scan of a latched word for a PAT_W-bit pattern, one
// window per cycle, overlapping (mode=0) or non-overlapping (mode=1).
// Ports: clk, rst (async, active-high), start, mode, din, pattern in;
// busy, done, count, found out. Defining SEQ_SCAN_FIRST_POS_EN adds the
// first_pos / first_vld outputs (index of the first matching window).
module seq_scan
    import seq_scan_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int PAT_W  = 3,
    localparam int NWIN   = DATA_W - PAT_W + 1,
    localparam int CNT_W  = $clog2(NWIN + 1),
    localparam int POS_W  = clog2_min1(NWIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] din,
    input  logic [PAT_W-1:0]  pattern,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              found
`ifdef SEQ_SCAN_FIRST_POS_EN
   ,output logic [POS_W-1:0]  first_pos,
    output logic              first_vld
`endif
);

    localparam int IDX_W  = POS_W;
    localparam int SKIP_W = clog2_min1(PAT_W);

    state_t            state;
    logic [DATA_W-1:0] din_q;
    logic [PAT_W-1:0]  pat_q;
    logic              mode_q;
    logic [IDX_W-1:0]  idx;
    logic [SKIP_W-1:0] skip;
    logic              hit;
    logic              take;
    logic              last;
    logic              accept;

    seq_win_match #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .IDX_W  (IDX_W)
    ) u_match (
        .word    (din_q),
        .index   (idx),
        .pattern (pat_q),
        .hit     (hit)
    );

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == IDX_W'(NWIN - 1));
    assign busy   = (state == SCAN);
    assign done   = (state == DONE);
    assign found  = (count != '0);

    // a hit is only counted when no earlier match is still being skipped
    always_comb begin
        take = 1'b0;
        unique case (mode_q)
            MODE_OVL:  take = hit;
            MODE_NOVL: take = hit && (skip == '0);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            din_q  <= '0;
            pat_q  <= '0;
            mode_q <= MODE_OVL;
            idx    <= '0;
            skip   <= '0;
            count  <= '0;
        end else if (accept) begin
            state  <= SCAN;
            din_q  <= din;
            pat_q  <= pattern;
            mode_q <= mode;
            idx    <= '0;
            skip   <= '0;
            count  <= '0;
        end else begin
            unique case (state)
                SCAN: begin
                    // skipped windows still burn a cycle: fixed latency
                    if (skip != '0)
                        skip <= skip - SKIP_W'(1);
                    else if (take && mode_q == MODE_NOVL)
                        skip <= SKIP_W'(PAT_W - 1);
                    if (take && count != '1)
                        count <= count + CNT_W'(1);
                    if (last)
                        state <= DONE;
                    else
                        idx <= idx + IDX_W'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_SCAN_FIRST_POS_EN
    logic [POS_W-1:0] fp_run;
    logic             fv_run;

    // tracked during the scan, published only on the last window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fp_run    <= '0;
            fv_run    <= 1'b0;
            first_pos <= '0;
            first_vld <= 1'b0;
        end else if (accept) begin
            fp_run    <= '0;
            fv_run    <= 1'b0;
            first_pos <= '0;
            first_vld <= 1'b0;
        end else if (state == SCAN) begin
            if (take && !fv_run) begin
                fv_run <= 1'b1;
                fp_run <= idx;
            end
            if (last) begin
                first_vld <= fv_run | take;
                first_pos <= fv_run ? fp_run : idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_scan.sv
// tb_seq_scan: directed and random scans of seq_scan (DATA_W=8, PAT_W=3)
// against a window-by-window reference model.
module tb_seq_scan;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 3;
    localparam int NWIN   = DATA_W - PAT_W + 1;
    localparam int CNT_W  = $clog2(NWIN + 1);
    localparam int POS_W  = $clog2(NWIN);
    localparam int LIMIT  = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [PAT_W-1:0]  pattern = '0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              found;
`ifdef SEQ_SCAN_FIRST_POS_EN
    logic [POS_W-1:0]  first_pos;
    logic              first_vld;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_scan #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .din     (din),
        .pattern (pattern),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .found   (found)
`ifdef SEQ_SCAN_FIRST_POS_EN
       ,.first_pos (first_pos),
        .first_vld (first_vld)
`endif
    );

    // reference: slide a window from the MSB end, skip after a match in mode 1
    function automatic void model(input logic [DATA_W-1:0] d,
                                  input logic [PAT_W-1:0] p,
                                  input logic m,
                                  output int cnt, output int fpos,
                                  output bit fv);
        int skip;
        logic [PAT_W-1:0] w;
        skip = 0; cnt = 0; fpos = 0; fv = 0;
        for (int i = 0; i < NWIN; i++) begin
            w = PAT_W'(d >> (DATA_W - PAT_W - i));
            if (skip > 0) begin
                skip--;
            end else if (w == p) begin
                cnt++;
                if (!fv) begin fv = 1; fpos = i; end
                if (m) skip = PAT_W - 1;
            end
        end
    endfunction

    // launch one scan; lat = edges from acceptance until done is seen
    task automatic scan(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                        input logic m, output int lat);
        @(negedge clk);
        din = d; pattern = p; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // operands must already be latched
        din = DATA_W'($urandom); pattern = PAT_W'($urandom); mode = 1'($urandom);
        lat = 0;
        while (!done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, found, count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {busy, done, found, count});
        end
`ifdef SEQ_SCAN_FIRST_POS_EN
        checks++;
        if ({first_vld, first_pos} !== '0) begin
            failures++;
            $display("FAIL reset_first got=%b exp=0", {first_vld, first_pos});
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [DATA_W-1:0] td [5] = '{8'hB6, 8'hFF, 8'hFF, 8'hB6, 8'h00};
        logic [PAT_W-1:0]  tp [5] = '{3'b101, 3'b111, 3'b111, 3'b110, 3'b001};
        logic              tm [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int                tc [5] = '{2, 6, 2, 2, 0};
        int                tf [5] = '{0, 0, 0, 2, 0};
        int lat;
        for (int k = 0; k < 5; k++) begin
            scan(td[k], tp[k], tm[k], lat);
            checks++;
            if (lat !== NWIN) begin
                failures++;
                $display("FAIL dir%0d_latency got=%0d exp=%0d", k, lat, NWIN);
            end
            checks++;
            if (count !== CNT_W'(tc[k]) || found !== (tc[k] != 0) || busy !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_result got=cnt%0d/f%0b/b%0b exp=cnt%0d/f%0b/b0",
                         k, count, found, busy, tc[k], tc[k] != 0);
            end
`ifdef SEQ_SCAN_FIRST_POS_EN
            checks++;
            if (first_vld !== (tc[k] != 0) || (tc[k] != 0 && first_pos !== POS_W'(tf[k]))) begin
                failures++;
                $display("FAIL dir%0d_first got=v%0b/p%0d exp=v%0b/p%0d",
                         k, first_vld, first_pos, tc[k] != 0, tf[k]);
            end
`endif
        end
    endtask

    task automatic test_hold();
        int lat;
        scan(8'hB6, 3'b101, 1'b0, lat);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (count !== CNT_W'(2) || found !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold got=cnt%0d/f%0b/d%0b/b%0b exp=cnt2/f1/d0/b0",
                     count, found, done, busy);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        logic [PAT_W-1:0]  p;
        logic              m;
        int lat, ec, ef;
        bit ev;
        for (int k = 0; k < 40; k++) begin
            d = DATA_W'($urandom);
            p = PAT_W'($urandom);
            m = 1'($urandom);
            if (k % 4 == 0) d = {DATA_W/PAT_W + 1{p}};
            model(d, p, m, ec, ef, ev);
            scan(d, p, m, lat);
            checks++;
            if (lat !== NWIN || count !== CNT_W'(ec) || found !== ev) begin
                failures++;
                $display("FAIL rand%0d d=%h p=%b m=%0b got=lat%0d/cnt%0d/f%0b exp=lat%0d/cnt%0d/f%0b",
                         k, d, p, m, lat, count, found, NWIN, ec, ev);
            end
`ifdef SEQ_SCAN_FIRST_POS_EN
            checks++;
            if (first_vld !== ev || (ev && first_pos !== POS_W'(ef))) begin
                failures++;
                $display("FAIL rand%0d_first got=v%0b/p%0d exp=v%0b/p%0d",
                         k, first_vld, first_pos, ev, ef);
            end
`endif
        end
    endtask

    task automatic test_start_ignored();
        int lat, ec, ef;
        bit ev;
        model(8'hB6, 3'b110, 1'b0, ec, ef, ev);
        @(negedge clk);
        din = 8'hB6; pattern = 3'b110; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < LIMIT) begin
            if (lat == 2) begin
                din = 8'hFF; pattern = 3'b111; mode = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== NWIN || count !== CNT_W'(ec)) begin
            failures++;
            $display("FAIL start_ignored got=lat%0d/cnt%0d exp=lat%0d/cnt%0d",
                     lat, count, NWIN, ec);
        end
    endtask

    task automatic test_back_to_back();
        int lat, gap, ec, ef;
        bit ev;
        scan(8'hFF, 3'b111, 1'b1, lat);
        checks++;
        if (done !== 1'b1 || count !== CNT_W'(2)) begin
            failures++;
            $display("FAIL b2b_first got=d%0b/cnt%0d exp=d1/cnt2", done, count);
        end
        model(8'hB6, 3'b101, 1'b0, ec, ef, ev);
        din = 8'hB6; pattern = 3'b101; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || count !== '0) begin
            failures++;
            $display("FAIL b2b_accept got=b%0b/cnt%0d exp=b1/cnt0", busy, count);
        end
        gap = 1;
        while (!done && gap < LIMIT) begin
            @(posedge clk); #1;
            gap++;
        end
        checks++;
        if (gap !== NWIN + 1 || count !== CNT_W'(ec)) begin
            failures++;
            $display("FAIL b2b_second got=gap%0d/cnt%0d exp=gap%0d/cnt%0d",
                     gap, count, NWIN + 1, ec);
        end
    endtask

    task automatic test_rst_midscan();
        int lat;
        @(negedge clk);
        din = 8'hFF; pattern = 3'b111; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, found, count} !== '0) begin
            failures++;
            $display("FAIL rst_midscan got=%b exp=0", {busy, done, found, count});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done, found, count} !== '0) begin
            failures++;
            $display("FAIL rst_held got=%b exp=0", {busy, done, found, count});
        end
        @(negedge clk);
        rst = 1'b0;
        din = 8'hB6; pattern = 3'b101; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_first_start got=b%0b exp=b1", busy);
        end
        lat = 0;
        while (!done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== NWIN || count !== CNT_W'(2)) begin
            failures++;
            $display("FAIL rst_rescan got=lat%0d/cnt%0d exp=lat%0d/cnt2", lat, count, NWIN);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_rst_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
